alu_issue_ctrl: RTL and testbench

//  Command issue/response stage wrapped around the combinational alu. Accepts one

---
 rtl/alu_issue_ctrl.sv | 84 ++++++++
 tb/tb_alu_issue_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready command issue and response stage around a combinational alu,
// with an accumulator usable as operand A and a wrapping count of consumed responses.
module alu_issue_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic                 cmd_use_acc,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [3:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_carry,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_illegal,
    output logic [WIDTH-1:0]     acc,
    output logic [CNT_WIDTH-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic legal, clr_acc;
    assign legal   = ~alu_op[3];
    assign clr_acc = &alu_op;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                state_nx  = cmd_valid ? EXEC : IDLE;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_illegal <= 1'b0;
            acc         <= '0;
            op_count    <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                alu_op <= cmd_op;
                alu_b  <= cmd_b;
                alu_a  <= cmd_use_acc ? acc : cmd_a;
            end
            // illegal ops and CLRACC report a zero result regardless of the alu output
            if (state == EXEC) begin
                rsp_result  <= legal ? alu_result : '0;
                rsp_flags   <= legal ? {alu_zero, alu_negative, alu_carry, alu_overflow} : 4'b1000;
                rsp_illegal <= ~legal & ~clr_acc;
                if (legal)        acc <= alu_result;
                else if (clr_acc) acc <= '0;
            end
            if (state == RESP && rsp_ready) op_count <= op_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives the issue stage with directed and random commands, supplies a
// behavioural alu, and compares every response against a transaction-level model.
module tb_alu_issue_ctrl;
    localparam int W  = 8;
    localparam int CW = 4;
    logic clk = 0, rst_n = 0;
    logic cmd_valid = 0, cmd_use_acc = 0, rsp_ready = 0;
    logic [3:0] cmd_op = 0;
    logic [W-1:0] cmd_a = 0, cmd_b = 0;
    logic cmd_ready, rsp_valid, rsp_illegal;
    logic [W-1:0] alu_a, alu_b, alu_result, rsp_result, acc;
    logic [3:0] alu_op, rsp_flags, alu_flags;
    logic [CW-1:0] op_count;
    int errors = 0, checks = 0;
    logic [W-1:0] acc_m = 0;
    int cnt_m = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_flags[3]), .alu_negative(alu_flags[2]), .alu_carry(alu_flags[1]),
        .alu_overflow(alu_flags[0]), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
        .acc(acc), .op_count(op_count)
    );

    // behavioural alu: {Z,N,C,V} result pack; illegal op codes give zero
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int r, c, v;
        c = 0; v = 0;
        case (op)
            0: begin r = a + b; c = r > 255; r = r % 256; v = (a[7] == b[7]) && (r[7] != a[7]); end
            1: begin r = (a - b + 256) % 256; c = a < b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = (a * 2) % 256; c = a[7]; end
            7: begin r = a / 2; c = a[0]; end
            default: r = 0;
        endcase
        return {(r == 0) ? 1'b1 : 1'b0, r[7], c[0], v[0], r[7:0]};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic use_acc, input int stall);
        logic [W-1:0] ea, er;
        logic [3:0] ef;
        logic eill;
        logic [11:0] p;
        logic [W-1:0] held;
        check("cmd_ready_idle", 16'(cmd_ready), 1);
        ea = use_acc ? acc_m : a;
        p = alu_fn(op, ea, b);
        if (op < 8) begin er = p[7:0]; ef = p[11:8]; eill = 0; acc_m = er; end
        else begin er = 0; ef = 4'b1000; eill = (op != 15); if (op == 15) acc_m = 0; end
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
        step;
        cmd_valid = 0; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 4'($urandom);
        check("exec_alu_a", 16'(alu_a), 16'(ea));
        check("exec_alu_b", 16'(alu_b), 16'(b));
        check("exec_alu_op", 16'(alu_op), 16'(op));
        check("exec_no_rsp", 16'(rsp_valid), 0);
        step;
        check("rsp_valid", 16'(rsp_valid), 1);
        check("rsp_result", 16'(rsp_result), 16'(er));
        check("rsp_flags", 16'(rsp_flags), 16'(ef));
        check("rsp_illegal", 16'(rsp_illegal), 16'(eill));
        check("acc", 16'(acc), 16'(acc_m));
        held = alu_a;
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1; cmd_use_acc = 0; cmd_a = $urandom;
            step;
            check("stall_rsp_valid", 16'(rsp_valid), 1);
            check("stall_cmd_ready", 16'(cmd_ready), 0);
            check("stall_rsp_result", 16'(rsp_result), 16'(er));
            check("stall_rsp_flags", 16'(rsp_flags), 16'(ef));
            check("stall_alu_a", 16'(alu_a), 16'(held));
            check("stall_op_count", 16'(op_count), 16'(cnt_m));
        end
        cmd_valid = 0; rsp_ready = 1;
        step;
        rsp_ready = 0;
        cnt_m = (cnt_m + 1) % (1 << CW);
        check("done_rsp_valid", 16'(rsp_valid), 0);
        check("done_op_count", 16'(op_count), 16'(cnt_m));
        check("done_alu_a_hold", 16'(alu_a), 16'(held));
    endtask

    initial begin
        repeat (2) step;
        check("rst_cmd_ready", 16'(cmd_ready), 1);
        check("rst_rsp_valid", 16'(rsp_valid), 0);
        check("rst_acc", 16'(acc), 0);
        check("rst_alu_op", 16'(alu_op), 0);
        check("rst_op_count", 16'(op_count), 0);
        rst_n = 1;
        step;
        run_cmd(4'd0, 8'h7F, 8'h01, 0, 0);
        check("add_acc", 16'(acc), 16'h80);
        check("add_flags", 16'(rsp_flags), 16'b0101);
        run_cmd(4'd1, 8'h00, 8'h80, 1, 0);
        check("sub_acc", 16'(acc), 0);
        run_cmd(4'd3, 8'h12, 8'h34, 0, 5);
        run_cmd(4'd0, 8'h40, 8'h40, 0, 0);
        run_cmd(4'd9, 8'h11, 8'h22, 0, 1);
        check("illegal_acc_kept", 16'(acc), 16'h80);
        run_cmd(4'd15, 8'hFF, 8'hFF, 0, 0);
        check("clracc_acc", 16'(acc), 0);
        run_cmd(4'd0, 8'hAA, 8'h05, 1, 0);
        // abort an op with reset while it is in EXEC
        cmd_valid = 1; cmd_op = 0; cmd_a = 8'h10; cmd_b = 8'h20; cmd_use_acc = 0;
        step;
        cmd_valid = 0;
        rst_n = 0;
        #1;
        check("abort_cmd_ready", 16'(cmd_ready), 1);
        check("abort_acc", 16'(acc), 0);
        check("abort_op_count", 16'(op_count), 0);
        step;
        rst_n = 1;
        acc_m = 0; cnt_m = 0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("abort_no_rsp", 16'(rsp_valid), 0);
        end
        run_cmd(4'd0, 8'h03, 8'h04, 0, 0);
        check("after_abort_acc", 16'(acc), 7);
        for (int i = 0; i < 60; i++)
            run_cmd(($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
